dac_sample_streamer: RTL and testbench
======================================

# dac_sample_streamer

Sample-rate engine directly upstream of the DAC pin interface in the PLB DAC peripheral. Buffers DAC samples written from the PLB slave register path in a small synchronous FIFO and emits them on `S_Data` / `S_DCLKIO` at a programmable rate. Handles priming, underrun and enable/disable, so software only needs to keep the FIFO topped up.

## Interface
Parameters:
- `DAC_WIDTH`, 10: sample width in bits.
- `FIFO_AWIDTH`, 4: log2 of the FIFO depth (16 entries).
- `DIV_WIDTH`, 16: width of the rate divider.
- `PRIME_LEVEL`, 4: FIFO level that must be reached before playback starts.

Ports:
- `SPLB_Clk`  in  1  sole clock.
- `SPLB_Rst`  in  1  synchronous, active-high reset.
- `Wr_Req`  in  1  sample write strobe from the register path.
- `Wr_Data`  in  [0:31]  sample in bits `[32-DAC_WIDTH:31]`; other bits ignored.
- `Wr_Ack`  out  1  combinational, `Wr_Req & ~Full`; the write is accepted this edge.
- `Enable`  in  1  playback enable (level).
- `Rate_Div`  in  [DIV_WIDTH-1:0]  sample period minus 1, in clocks; values 0 and 1 both mean a period of 2.
- `Clr_Underrun`  in  1  clears `Underrun`.
- `Full`  out  1
- `Empty`  out  1
- `Level`  out  [FIFO_AWIDTH:0]  FIFO occupancy.
- `Underrun`  out  1  sticky flag.
- `S_Data`  out  [0:DAC_WIDTH-1]  registered sample to the DAC.
- `S_DCLKIO`  out  1  registered DAC sample clock.

## Operation
- **FIFO:** push on `Wr_Req & ~Full`. Pop only on a playback tick.
  - Push and pop in the same cycle: `Level` is unchanged.
  - Push while empty followed by a pop tick in the same cycle: no bypass. This counts as an underrun.
- **States:** `IDLE`, `PRIME`, `RUN`.
  - `IDLE`: period counter held at 0; `S_Data` = midscale (`1<<(DAC_WIDTH-1)`, 0x200); `S_DCLKIO` = 0. Goes to `PRIME` when `Enable`=1.
  - `PRIME`: outputs as in `IDLE`. Goes to `RUN` when `Level >= PRIME_LEVEL` or `Full`. Goes to `IDLE` if `Enable`=0.
  - `RUN`: counter `cnt` counts 0..P-1, where P = max(`Rate_Div`,1)+1.
    - Tick when `cnt == P-1`: pop the FIFO. `S_Data` takes the popped sample on the edge where `cnt` wraps to 0.
    - Tick with the FIFO empty: `S_Data` holds its last value and `Underrun` is set.
    - Goes to `IDLE` on the edge after `Enable`=0; `S_Data` returns to midscale and the FIFO contents are kept.
- **S_DCLKIO in RUN:** 0 for `cnt` < ceil(P/2), 1 otherwise. The DAC latches on the rising edge, mid-period, while data is stable.
- **Rate_Div changes:** sampled only at wrap, so a period in progress completes with the old value.
- **Underrun:** set on an empty tick. `Clr_Underrun` clears it. If set and clear happen in the same cycle, set wins.
- **Reset:**
  - `S_Data` = 0x200, `S_DCLKIO` = 0, `Underrun` = 0.
  - FIFO empty: `Level` = 0, `Empty` = 1, `Full` = 0.
  - State = `IDLE`.
  - Reset asserted mid-operation discards FIFO contents and restores all reset values on the next edge.

## Timing
- Write-to-flag latency is 1 cycle: after an accepted push, `Level`, `Empty` and `Full` update on the next edge.
- Entering `RUN`: `cnt` = 0 on the first `RUN` cycle. The first sample appears on `S_Data` P cycles after `RUN` entry.
- `S_Data` and `S_DCLKIO` are both registered with no output glitches. `S_Data` changes only when `cnt` is 0.
- Throughput is one sample per P cycles; the minimum P is 2.

## Configuration
- `DAC_STREAMER_TWOS_COMP_EN`:
  - Defined: the input sample is two's complement. Its MSB is inverted when loaded into `S_Data` (offset binary out).
  - Undefined: samples pass through unchanged.
  - Idle and reset values are 0x200 in both builds.

## Structure
- Package `dac_stream_pkg`: state enum (`IDLE`/`PRIME`/`RUN`) and the midscale constant function of `DAC_WIDTH`.
- Sub-module `dac_sample_fifo`: synchronous FIFO, depth 2^`FIFO_AWIDTH`, with `Level`/`Full`/`Empty` outputs. The top level holds the state machine, period counter, clock generation and output registers.

## Test plan
- Reset, then `Enable`=1 with no writes → state stays `PRIME`; `S_Data`=0x200 and `S_DCLKIO`=0 indefinitely.
- Write 0x001,0x002,0x003,0x004, with `Rate_Div`=3, `Enable`=1 → `RUN` entered; `S_Data` steps 1,2,3,4 every 4 cycles; `S_DCLKIO` is high for `cnt` 2–3.
- Continue the previous case with no further writes → the 5th tick sets `Underrun`=1 and `S_Data` holds 0x004. `Clr_Underrun` clears the flag, unless a tick on that same cycle sets it again.
- Write 17 samples while `Enable`=0 → 16 accepted; the 17th sees `Wr_Ack`=0; `Full`=1 and `Level`=16.
- Drop `Enable` mid-`RUN` with `Level`=5 → `IDLE` on the next edge; `S_Data`=0x200; `Level` stays 5.
- Build with `DAC_STREAMER_TWOS_COMP_EN` and write 0x000, 0x1FF, 0x200 → outputs 0x200, 0x3FF, 0x000.

Source files
------------

// File: rtl/dac_stream_pkg.sv
// Shared types and constants for the DAC sample streamer: playback state
// encoding and the midscale (zero-signal) code for a given sample width.
package dac_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO, depth 2**AW, with occupancy, full and empty flags.
// Overflowing pushes and underflowing pops are ignored.
module dac_sample_fifo #(
  parameter int DW = 10,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full_o    = (count_q == DEPTH);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign level_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dac_sample_streamer.sv
// Paces FIFO'd DAC samples onto S_Data/S_DCLKIO at one sample per Rate_Div+1 clocks.
// Optional build macro DAC_STREAMER_TWOS_COMP_EN: convert two's complement input to offset binary.
module dac_sample_streamer
  import dac_stream_pkg::*;
#(
  parameter int DAC_WIDTH   = 10,
  parameter int FIFO_AWIDTH = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                   SPLB_Clk,
  input  logic                   SPLB_Rst,
  input  logic                   Wr_Req,
  input  logic [0:31]            Wr_Data,
  output logic                   Wr_Ack,
  input  logic                   Enable,
  input  logic [DIV_WIDTH-1:0]   Rate_Div,
  input  logic                   Clr_Underrun,
  output logic                   Full,
  output logic                   Empty,
  output logic [FIFO_AWIDTH:0]   Level,
  output logic                   Underrun,
  output logic [0:DAC_WIDTH-1]   S_Data,
  output logic                   S_DCLKIO
);

  localparam logic [DAC_WIDTH-1:0]  MIDSCALE  = DAC_WIDTH'(midscale(DAC_WIDTH));
  localparam logic [FIFO_AWIDTH:0]  PRIME_LVL = (FIFO_AWIDTH+1)'(PRIME_LEVEL);

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DIV_WIDTH-1:0]   pm1_q;
  logic [DAC_WIDTH-1:0]   s_data_q;
  logic                   dclk_q;
  logic                   underrun_q, underrun_d;

  logic [DAC_WIDTH-1:0]   wr_sample_s, rd_sample_s, load_sample_s;
  logic [FIFO_AWIDTH:0]   fifo_level_s;
  logic                   fifo_full_s, fifo_empty_s;
  logic [DIV_WIDTH-1:0]   rate_sel_s;
  logic [DIV_WIDTH:0]     half_s, cnt_inc_s;
  logic                   tick_s, pop_s;

  assign wr_sample_s = Wr_Data[32-DAC_WIDTH:31];
  assign Wr_Ack      = Wr_Req & ~fifo_full_s;

  dac_sample_fifo #(
    .DW (DAC_WIDTH),
    .AW (FIFO_AWIDTH)
  ) u_fifo (
    .clk_i   (SPLB_Clk),
    .rst_i   (SPLB_Rst),
    .push_i  (Wr_Req),
    .wdata_i (wr_sample_s),
    .pop_i   (pop_s),
    .rdata_o (rd_sample_s),
    .level_o (fifo_level_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef DAC_STREAMER_TWOS_COMP_EN
  assign load_sample_s = {~rd_sample_s[DAC_WIDTH-1], rd_sample_s[DAC_WIDTH-2:0]};
`else
  assign load_sample_s = rd_sample_s;
`endif

  // pm1 is the period minus one; a divider of 0 is promoted to 1 (minimum period 2)
  assign rate_sel_s = (Rate_Div == {DIV_WIDTH{1'b0}}) ? {{(DIV_WIDTH-1){1'b0}}, 1'b1} : Rate_Div;
  assign half_s     = ({1'b0, pm1_q} + {{(DIV_WIDTH-1){1'b0}}, 2'b10}) >> 1;
  assign cnt_inc_s  = {1'b0, cnt_q} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign tick_s     = (state_q == RUN) && Enable && (cnt_q == pm1_q);
  assign pop_s      = tick_s & ~fifo_empty_s;

  // Sticky underrun: a set on the same cycle as a clear wins
  always_comb begin
    underrun_d = underrun_q;
    if (tick_s && fifo_empty_s) begin
      underrun_d = 1'b1;
    end else if (Clr_Underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Playback state machine, period counter and output registers
  always_ff @(posedge SPLB_Clk) begin
    if (SPLB_Rst) begin
      state_q    <= IDLE;
      cnt_q      <= {DIV_WIDTH{1'b0}};
      pm1_q      <= {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      s_data_q   <= MIDSCALE;
      dclk_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      case (state_q)
        IDLE: begin
          cnt_q    <= {DIV_WIDTH{1'b0}};
          s_data_q <= MIDSCALE;
          dclk_q   <= 1'b0;
          if (Enable) begin
            state_q <= PRIME;
          end
        end
        PRIME: begin
          cnt_q    <= {DIV_WIDTH{1'b0}};
          s_data_q <= MIDSCALE;
          dclk_q   <= 1'b0;
          if (!Enable) begin
            state_q <= IDLE;
          end else if ((fifo_level_s >= PRIME_LVL) || fifo_full_s) begin
            state_q <= RUN;
            pm1_q   <= rate_sel_s;
          end
        end
        RUN: begin
          if (!Enable) begin
            state_q  <= IDLE;
            cnt_q    <= {DIV_WIDTH{1'b0}};
            s_data_q <= MIDSCALE;
            dclk_q   <= 1'b0;
          end else if (tick_s) begin
            // Wrap: new divider takes effect only for the period now starting
            cnt_q  <= {DIV_WIDTH{1'b0}};
            pm1_q  <= rate_sel_s;
            dclk_q <= 1'b0;
            if (!fifo_empty_s) begin
              s_data_q <= load_sample_s;
            end
          end else begin
            cnt_q  <= cnt_inc_s[DIV_WIDTH-1:0];
            dclk_q <= (cnt_inc_s >= half_s);
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= {DIV_WIDTH{1'b0}};
          s_data_q <= MIDSCALE;
          dclk_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Full     = fifo_full_s;
  assign Empty    = fifo_empty_s;
  assign Level    = fifo_level_s;
  assign Underrun = underrun_q;
  assign S_Data   = s_data_q;
  assign S_DCLKIO = dclk_q;

endmodule

// File: tb/tb_dac_sample_streamer.sv
// Directed self-checking bench for dac_sample_streamer; cycle k counts rising edges since Enable rose.
module tb_dac_sample_streamer;

  logic        SPLB_Clk = 1'b0;
  logic        SPLB_Rst;
  logic        Wr_Req;
  logic [0:31] Wr_Data;
  logic        Wr_Ack;
  logic        Enable;
  logic [15:0] Rate_Div;
  logic        Clr_Underrun;
  logic        Full;
  logic        Empty;
  logic [4:0]  Level;
  logic        Underrun;
  logic [0:9]  S_Data;
  logic        S_DCLKIO;

  int checks = 0;
  int errors = 0;

  always #5 SPLB_Clk = ~SPLB_Clk;

  dac_sample_streamer dut (
    .SPLB_Clk     (SPLB_Clk),
    .SPLB_Rst     (SPLB_Rst),
    .Wr_Req       (Wr_Req),
    .Wr_Data      (Wr_Data),
    .Wr_Ack       (Wr_Ack),
    .Enable       (Enable),
    .Rate_Div     (Rate_Div),
    .Clr_Underrun (Clr_Underrun),
    .Full         (Full),
    .Empty        (Empty),
    .Level        (Level),
    .Underrun     (Underrun),
    .S_Data       (S_Data),
    .S_DCLKIO     (S_DCLKIO)
  );

  task automatic step();
    @(negedge SPLB_Clk);
  endtask

  task automatic do_reset();
    SPLB_Rst     = 1'b1;
    Wr_Req       = 1'b0;
    Wr_Data      = 32'd0;
    Enable       = 1'b0;
    Clr_Underrun = 1'b0;
    step();
    SPLB_Rst = 1'b0;
  endtask

  // Upper 22 bits carry junk that the DUT must ignore
  task automatic write_sample(input logic [9:0] v);
    Wr_Req  = 1'b1;
    Wr_Data = {22'h2AAAAA, v};
    step();
    Wr_Req  = 1'b0;
  endtask

  task automatic test_reset();
    Rate_Div = 16'd3;
    do_reset();
    checks++;
    if (S_Data !== 10'h200) begin errors++; $display("FAIL reset_sdata got %h want 200", S_Data); end
    checks++;
    if (S_DCLKIO !== 1'b0 || Underrun !== 1'b0) begin
      errors++; $display("FAIL reset_dclk_underrun got %b%b want 00", S_DCLKIO, Underrun);
    end
    checks++;
    if (Level !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
      errors++; $display("FAIL reset_fifo got level=%0d empty=%b full=%b want 0 1 0", Level, Empty, Full);
    end
  endtask

  task automatic test_prime_hold();
    do_reset();
    Enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        write_sample(10'h011);
        write_sample(10'h012);
        write_sample(10'h013);
      end else begin
        step();
      end
      checks++;
      if (S_Data !== 10'h200 || S_DCLKIO !== 1'b0 || Underrun !== 1'b0) begin
        errors++;
        $display("FAIL prime_hold i=%0d got data=%h dclk=%b und=%b want 200 0 0", i, S_Data, S_DCLKIO, Underrun);
      end
    end
    checks++;
    if (Level !== 5'd3) begin errors++; $display("FAIL prime_level got %0d want 3", Level); end
  endtask

  task automatic test_playback_underrun();
    int n;
    logic [9:0] exp_data;
    logic       exp_dclk, exp_und;
    logic [4:0] exp_lvl;
    do_reset();
    Rate_Div = 16'd3;
    for (int v = 1; v <= 4; v++) write_sample(10'(v));
    checks++;
    if (Level !== 5'd4 || Empty !== 1'b0) begin
      errors++; $display("FAIL play_prefill got level=%0d empty=%b want 4 0", Level, Empty);
    end
    Enable = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      n        = (k >= 2) ? (k - 2) / 4 : 0;
      exp_data = (n == 0) ? 10'h200 : ((n > 4) ? 10'd4 : 10'(n));
      exp_dclk = (k >= 2) && (((k - 2) % 4) >= 2);
      exp_und  = (k == 22) || (k == 26);
      exp_lvl  = (n > 4) ? 5'd0 : 5'(4 - n);
      checks++;
      if (S_Data !== exp_data) begin errors++; $display("FAIL play_data k=%0d got %h want %h", k, S_Data, exp_data); end
      checks++;
      if (S_DCLKIO !== exp_dclk) begin errors++; $display("FAIL play_dclk k=%0d got %b want %b", k, S_DCLKIO, exp_dclk); end
      checks++;
      if (Underrun !== exp_und) begin errors++; $display("FAIL play_underrun k=%0d got %b want %b", k, Underrun, exp_und); end
      checks++;
      if (Level !== exp_lvl) begin errors++; $display("FAIL play_level k=%0d got %0d want %0d", k, Level, exp_lvl); end
      Clr_Underrun = (k == 22) || (k == 25) || (k == 26);
    end
    Clr_Underrun = 1'b0;
    Enable = 1'b0;
    step();
    checks++;
    if (S_Data !== 10'h200 || S_DCLKIO !== 1'b0) begin
      errors++; $display("FAIL play_disable got data=%h dclk=%b want 200 0", S_Data, S_DCLKIO);
    end
  endtask

  task automatic test_fill_disable();
    int n;
    logic [9:0] exp_data;
    logic       exp_dclk;
    logic [4:0] exp_lvl;
    do_reset();
    Rate_Div = 16'd0;
    for (int i = 0; i <= 16; i++) begin
      Wr_Req  = 1'b1;
      Wr_Data = {22'h155555, 10'(16'h100 + i)};
      #1;
      checks++;
      if (Wr_Ack !== (i < 16)) begin errors++; $display("FAIL fill_ack i=%0d got %b want %b", i, Wr_Ack, (i < 16)); end
      step();
    end
    Wr_Req = 1'b0;
    checks++;
    if (Full !== 1'b1 || Level !== 5'd16 || Empty !== 1'b0) begin
      errors++; $display("FAIL fill_flags got full=%b level=%0d empty=%b want 1 16 0", Full, Level, Empty);
    end
    Enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      n        = (k >= 2) ? (k - 2) / 2 : 0;
      exp_data = (n == 0) ? 10'h200 : 10'(16'h100 + n - 1);
      exp_dclk = (k >= 2) && (((k - 2) % 2) == 1);
      exp_lvl  = 5'(16 - n);
      checks++;
      if (S_Data !== exp_data || S_DCLKIO !== exp_dclk || Level !== exp_lvl) begin
        errors++;
        $display("FAIL fast_run k=%0d got data=%h dclk=%b level=%0d want %h %b %0d",
                 k, S_Data, S_DCLKIO, Level, exp_data, exp_dclk, exp_lvl);
      end
    end
    Enable = 1'b0;
    step();
    checks++;
    if (S_Data !== 10'h200 || S_DCLKIO !== 1'b0 || Level !== 5'd5) begin
      errors++; $display("FAIL disable_mid_run got data=%h dclk=%b level=%0d want 200 0 5", S_Data, S_DCLKIO, Level);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (Level !== 5'd5 || S_Data !== 10'h200) begin
      errors++; $display("FAIL idle_keeps_fifo got level=%0d data=%h want 5 200", Level, S_Data);
    end
    SPLB_Rst = 1'b1;
    step();
    SPLB_Rst = 1'b0;
    checks++;
    if (Level !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0 || S_Data !== 10'h200 || Underrun !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got level=%0d empty=%b full=%b data=%h und=%b want 0 1 0 200 0",
               Level, Empty, Full, S_Data, Underrun);
    end
  endtask

  task automatic test_sample_format();
    logic [9:0] exp0, exp1, exp2;
`ifdef DAC_STREAMER_TWOS_COMP_EN
    exp0 = 10'h200; exp1 = 10'h3FF; exp2 = 10'h000;
`else
    exp0 = 10'h000; exp1 = 10'h1FF; exp2 = 10'h200;
`endif
    do_reset();
    Rate_Div = 16'd1;
    write_sample(10'h000);
    write_sample(10'h1FF);
    write_sample(10'h200);
    write_sample(10'h200);
    Enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (S_Data !== exp0) begin errors++; $display("FAIL format_s0 got %h want %h", S_Data, exp0); end
      end else if (k == 6) begin
        checks++;
        if (S_Data !== exp1) begin errors++; $display("FAIL format_s1 got %h want %h", S_Data, exp1); end
      end else if (k == 8) begin
        checks++;
        if (S_Data !== exp2) begin errors++; $display("FAIL format_s2 got %h want %h", S_Data, exp2); end
      end
    end
    Enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_prime_hold();
    test_playback_underrun();
    test_fill_disable();
    test_sample_format();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
